branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 134 +++++++++++++
 tb/tb_branch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Instruction sequencer: fetches one word at a time, resolves branches itself and
// hands every other opcode to an external datapath, waiting for its completion.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        flag_we,
  input  logic        alu_carry,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        taken,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RESOLVE, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_B, OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BL, OP_BCY, OP_BNCY, OP_HALT, OP_EXEC
  } op_t;

  state_t      state, next_state;
  op_t         op;
  logic [31:0] ir;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        carry;
  logic        cond;

  // Decode of the latched word; the halt opcode takes priority so a parameter
  // colliding with a branch encoding still stops the machine.
  always_comb begin
    op = OP_EXEC;
    if (ir[31:26] == HALT_OP) begin
      op = OP_HALT;
    end else begin
      case (ir[31:26])
        6'b101000: op = OP_B;
        6'b100000: op = OP_BR;
        6'b110000: op = OP_BLTZ;
        6'b110001: op = OP_BZ;
        6'b110010: op = OP_BNZ;
        6'b101011: op = OP_BL;
        6'b101001: op = OP_BCY;
        6'b101010: op = OP_BNCY;
        default:   op = OP_EXEC;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    pc_inc     = pc + 32'd1;
    target     = pc_inc;
    cond       = 1'b0;

    case (op)
      OP_B, OP_BL, OP_BCY, OP_BNCY: target = pc_inc + {{6{ir[25]}}, ir[25:0]};
      OP_BLTZ, OP_BZ, OP_BNZ:       target = pc_inc + {{16{ir[15]}}, ir[15:0]};
      OP_BR:                        target = rs_data;
      default:                      target = pc_inc;
    endcase

    case (op)
      OP_B, OP_BR, OP_BL: cond = 1'b1;
      OP_BLTZ:            cond = rs_data[31];
      OP_BZ:              cond = (rs_data == 32'd0);
      OP_BNZ:             cond = (rs_data != 32'd0);
      OP_BCY:             cond = carry;
      OP_BNCY:            cond = ~carry;
      default:            cond = 1'b0;
    endcase

    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   if (instr_valid) next_state = S_DECODE;
      S_DECODE:  next_state = (op == OP_HALT) ? S_HALT : S_RESOLVE;
      S_RESOLVE: next_state = (op == OP_EXEC) ? S_EXEC : S_FETCH;
      S_EXEC:    if (exec_done) next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= 32'd0;
      carry      <= 1'b0;
      link_data  <= 32'd0;
      imem_req   <= 1'b0;
      exec_start <= 1'b0;
      link_we    <= 1'b0;
      taken      <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= next_state;
      // Control outputs are flops decoded from the upcoming state, so they line
      // up with the state they describe without any combinational path out.
      imem_req   <= (next_state == S_FETCH);
      halted     <= (next_state == S_HALT);
      exec_start <= (state == S_DECODE) && (op == OP_EXEC);
      link_we    <= (state == S_DECODE) && (op == OP_BL);
      taken      <= (state == S_RESOLVE) && cond;

      if (state == S_FETCH && instr_valid) ir <= instr;
      if (state == S_DECODE && op == OP_BL) link_data <= pc_inc;

      if (state == S_RESOLVE && op != OP_EXEC) pc <= cond ? target : pc_inc;

      if (state == S_EXEC && exec_done) begin
        pc <= pc_inc;
        if (flag_we) carry <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios followed by random
// instruction streams compared against an instruction-level reference model.
module tb_branch_sequencer;

  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] OPB = 6'b101000, OPBR = 6'b100000, OPBLTZ = 6'b110000,
                         OPBZ = 6'b110001, OPBNZ = 6'b110010, OPBL = 6'b101011,
                         OPBCY = 6'b101001, OPBNCY = 6'b101010, OPALU = 6'b000001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic        flag_we = 1'b0;
  logic        alu_carry = 1'b0;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_data;
  logic        taken;
  logic        halted;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  logic        m_carry;

  branch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req),
    .instr_valid(instr_valid), .instr(instr), .rs_data(rs_data),
    .exec_start(exec_start), .exec_done(exec_done), .flag_we(flag_we),
    .alu_carry(alu_carry), .pc(pc), .link_we(link_we), .link_data(link_data),
    .taken(taken), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference: what one instruction does to pc, given the
  // architectural state before it.
  function automatic void model(input logic [31:0] ins, input logic [31:0] rs,
                                input logic [31:0] cur, input logic cy,
                                output logic [31:0] npc, output logic tk,
                                output logic ex, output logic lk, output logic hlt);
    int          off26, off16;
    logic [31:0] t26, t16;
    logic [5:0]  opc;
    opc   = ins[31:26];
    off26 = $signed(ins[25:0]);
    off16 = $signed(ins[15:0]);
    t26   = cur + 32'd1 + off26;
    t16   = cur + 32'd1 + off16;
    tk = 1'b0; ex = 1'b0; lk = 1'b0; hlt = 1'b0;
    npc = cur + 32'd1;
    if (opc == HALT) begin
      hlt = 1'b1;
      npc = cur;
    end else begin
      case (opc)
        OPB:     begin tk = 1'b1;           npc = t26; end
        OPBL:    begin tk = 1'b1; lk = 1'b1; npc = t26; end
        OPBR:    begin tk = 1'b1;           npc = rs;  end
        OPBLTZ:  begin tk = rs[31];         if (tk) npc = t16; end
        OPBZ:    begin tk = (rs == 0);      if (tk) npc = t16; end
        OPBNZ:   begin tk = (rs != 0);      if (tk) npc = t16; end
        OPBCY:   begin tk = cy;             if (tk) npc = t26; end
        OPBNCY:  begin tk = !cy;            if (tk) npc = t26; end
        default: ex = 1'b1;
      endcase
    end
  endfunction

  function automatic logic [31:0] mk26(input logic [5:0] op, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, v[25:0]};
  endfunction

  function automatic logic [31:0] mk16(input logic [5:0] op, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, 10'h2a5, v[15:0]};
  endfunction

  // Pull reset asynchronously, check outputs immediately, then release and make
  // sure the block sits idle; optionally fires a stale exec_done after release.
  task automatic do_reset(input string tag, input bit late_done);
    exec_done = 1'b0; flag_we = 1'b0; instr_valid = 1'b0; start = 1'b0;
    rst = 1'b0;
    #1;
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_ctl"}, {exec_start, link_we, taken, halted}, 0);
    check({tag, "_link_data"}, link_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_pc = 32'h0;
    m_carry = 1'b0;
    if (late_done) begin
      exec_done = 1'b1; flag_we = 1'b1; alu_carry = 1'b1;
    end
    @(negedge clk);
    exec_done = 1'b0; flag_we = 1'b0; alu_carry = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_idle_req"}, imem_req, 0);
    check({tag, "_idle_pc"}, pc, 32'h0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, imem_req, 1);
  endtask

  // Run one instruction through the DUT and compare its visible effects with the model.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs,
                           input int exec_delay, input bit fwe, input bit cy);
    logic [31:0] e_npc, got_link;
    logic        e_tk, e_ex, e_lk, e_halt;
    int          n_ex, n_tk, n_lk, wait_cnt;
    bit          done_sent, exited;
    model(ins, rs, m_pc, m_carry, e_npc, e_tk, e_ex, e_lk, e_halt);
    wait_req("fetch");
    check("fetch_pc", pc, m_pc);
    repeat ($urandom_range(0, 2)) begin
      instr = $urandom;
      @(negedge clk);
    end
    instr = ins; rs_data = rs; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom;
    n_ex = 0; n_tk = 0; n_lk = 0; got_link = 32'h0;
    wait_cnt = -1; done_sent = 1'b0; exited = 1'b0;
    for (int n = 0; n < 40 && !exited; n++) begin
      @(negedge clk);
      if (exec_start) n_ex++;
      if (taken) n_tk++;
      if (link_we) begin n_lk++; got_link = link_data; end
      exec_done = 1'b0; flag_we = 1'b0; alu_carry = 1'b0;
      if (imem_req || halted) begin
        instr_valid = 1'b0;
        exited = 1'b1;
      end else begin
        instr_valid = $urandom_range(0, 1) == 1;
        if (exec_start) begin
          wait_cnt = exec_delay;
        end else if (wait_cnt >= 0 && !done_sent) begin
          if (wait_cnt == 0) begin
            exec_done = 1'b1; flag_we = fwe; alu_carry = cy; done_sent = 1'b1;
          end else begin
            flag_we = $urandom_range(0, 1) == 1; alu_carry = $urandom_range(0, 1) == 1;
          end
          wait_cnt--;
        end
      end
    end
    check("instr_completed", exited, 1);
    check("exec_start_pulses", n_ex, e_ex);
    check("taken_pulses", n_tk, e_tk);
    check("link_we_pulses", n_lk, e_lk);
    if (e_lk) check("link_data", got_link, m_pc + 32'd1);
    check("halted", halted, e_halt);
    check("next_pc", pc, e_npc);
    if (e_ex && fwe) m_carry = cy;
    m_pc = e_npc;
  endtask

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] rnd_ins, rnd_rs;
    logic [5:0]  rnd_op;
    int          n;
    ops = '{OPB, OPBR, OPBLTZ, OPBZ, OPBNZ, OPBL, OPBCY, OPBNCY, OPALU, 6'b011100};
    m_pc = 32'h0;
    m_carry = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("por", 1'b0);

    // b / bz directed
    do_start();
    run_instr(mk26(OPB, 5), 32'h0, 0, 0, 0);
    check("b_target", m_pc, 32'd6);
    run_instr(mk26(OPB, 3), 32'h0, 0, 0, 0);
    run_instr(mk16(OPBZ, -2), 32'h0, 0, 0, 0);
    check("bz_taken_pc", pc, 32'd9);
    run_instr(mk26(OPALU, 0), 32'h0, 1, 0, 0);
    run_instr(mk16(OPBZ, -2), 32'd7, 0, 0, 0);
    check("bz_not_taken_pc", pc, 32'd11);

    // reset while fetching
    wait_req("pre_fetch_rst");
    do_reset("fetch_rst", 1'b0);

    // carry flag, bcy / bncy, bl wrap, br, halt
    do_start();
    run_instr(mk26(OPALU, 0), 32'h0, 3, 1, 1);
    run_instr(mk26(OPBCY, 3), 32'h0, 0, 0, 0);
    check("bcy_pc", pc, 32'd5);
    run_instr(mk26(OPBNCY, 3), 32'h0, 0, 0, 0);
    run_instr(mk26(OPBR, 0), 32'hFFFF_FFFE, 0, 0, 0);
    run_instr(mk26(OPBL, 1), 32'h0, 0, 0, 0);
    check("bl_wrap_pc", pc, 32'h0);
    run_instr(mk26(OPBR, 0), 32'h40, 0, 0, 0);
    run_instr(mk26(OPBR, 0), 32'h8, 0, 0, 0);
    run_instr({HALT, 26'h0}, 32'h0, 0, 0, 0);
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (imem_req) n++;
    end
    check("halt_no_req", n, 0);
    check("halt_hold", halted, 1);
    check("halt_pc", pc, 32'h8);

    // reset in the middle of EXEC, then a stale exec_done
    do_reset("halt_rst", 1'b0);
    do_start();
    run_instr(mk26(OPB, 5), 32'h0, 0, 0, 0);
    wait_req("exec_rst");
    instr = mk26(OPALU, 0); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!exec_start && n < 10) begin @(negedge clk); n++; end
    check("exec_rst_start_seen", exec_start, 1);
    @(negedge clk);
    check("exec_rst_pc_before", pc, 32'd6);
    do_reset("exec_rst", 1'b1);
    do_start();
    run_instr(mk26(OPBCY, 3), 32'h0, 0, 0, 0);
    check("carry_cleared_by_reset", pc, 32'd1);

    // random instruction streams
    for (int i = 0; i < 200; i++) begin
      rnd_op = ops[$urandom_range(0, 9)];
      if (rnd_op == 6'b011100) rnd_op = 6'($urandom_range(0, 62));
      rnd_ins = {rnd_op, 26'($urandom)};
      case ($urandom_range(0, 3))
        0:       rnd_rs = 32'h0;
        1:       rnd_rs = 32'h8000_0000 | $urandom;
        default: rnd_rs = $urandom;
      endcase
      run_instr(rnd_ins, rnd_rs, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
    end
    run_instr({HALT, 26'($urandom)}, 32'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
